// File: rtl/hnf_loc_sram_seq.sv
// Sequencer/arbiter for the HNF tag (loc) SRAM port: reset-time zeroing sweep, then cpl vs invalidate-sweep sharing.
// Optional feature: define HNF_LOC_SWEEP_STARVE_EN to force one sweep slot after STARVE_MAX consecutive cpl grants in SWEEP.
module hnf_loc_sram_seq #(
    parameter int IDX_W      = 10,
    parameter int WAY_NUM    = 16,
    parameter int CLINE_W    = 32,
    parameter int STARVE_MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cpl_req_valid,
    output logic                       cpl_req_ready,
    input  logic [IDX_W-1:0]           cpl_req_index,
    input  logic                       cpl_req_rd_en,
    input  logic [WAY_NUM-1:0]         cpl_req_wr_ways,
    input  logic [CLINE_W-1:0]         cpl_req_wr_cline,
    output logic                       cpl_rd_valid,
    output logic [CLINE_W*WAY_NUM-1:0] cpl_rd_clines,
    input  logic                       sweep_start,
    output logic                       sweep_busy,
    output logic                       sweep_done,
    output logic                       init_done,
    output logic [IDX_W-1:0]           loc_index_q,
    output logic                       loc_rd_en_q,
    output logic [WAY_NUM-1:0]         loc_wr_ways_q,
    output logic [CLINE_W-1:0]         loc_wr_cline_q,
    input  logic [CLINE_W*WAY_NUM-1:0] loc_rd_clines_q
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SWEEP
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
    logic [IDX_W-1:0]   loc_index_d;
    logic               loc_rd_en_d;
    logic [WAY_NUM-1:0] loc_wr_ways_d;
    logic [CLINE_W-1:0] loc_wr_cline_d;
    logic               cpl_rd_valid_q, cpl_rd_valid_d;
    logic               sweep_done_q, sweep_done_d;
    logic               init_done_q, init_done_d;
    logic               cpl_gnt;
    logic               sweep_gnt;

`ifdef HNF_LOC_SWEEP_STARVE_EN
    localparam int STARVE_W = ($clog2(STARVE_MAX + 1) < 4) ? 4 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                forced_slot;

    assign forced_slot = (state_q == ST_SWEEP) && (starve_q == STARVE_LIM);
`endif

    always_comb begin
        state_d        = state_q;
        sweep_idx_d    = sweep_idx_q;
        loc_index_d    = loc_index_q;
        loc_rd_en_d    = 1'b0;
        loc_wr_ways_d  = '0;
        loc_wr_cline_d = loc_wr_cline_q;
        sweep_done_d   = 1'b0;
        cpl_req_ready  = 1'b0;
`ifdef HNF_LOC_SWEEP_STARVE_EN
        starve_d       = '0;
`endif

        case (state_q)
            ST_IDLE:  cpl_req_ready = 1'b1;
`ifdef HNF_LOC_SWEEP_STARVE_EN
            ST_SWEEP: cpl_req_ready = !forced_slot;
`else
            ST_SWEEP: cpl_req_ready = 1'b1;
`endif
            default:  cpl_req_ready = 1'b0;
        endcase

        cpl_gnt   = cpl_req_valid && cpl_req_ready;
        sweep_gnt = (state_q == ST_INIT) || ((state_q == ST_SWEEP) && !cpl_gnt);

        if (cpl_gnt) begin
            loc_index_d    = cpl_req_index;
            loc_rd_en_d    = cpl_req_rd_en;
            loc_wr_ways_d  = cpl_req_wr_ways;
            loc_wr_cline_d = cpl_req_wr_cline;
        end else if (sweep_gnt) begin
            loc_index_d    = sweep_idx_q;
            loc_wr_ways_d  = '1;
            loc_wr_cline_d = '0;
            sweep_idx_d    = sweep_idx_q + IDX_W'(1);
        end

`ifdef HNF_LOC_SWEEP_STARVE_EN
        if ((state_q == ST_SWEEP) && cpl_gnt) begin
            starve_d = starve_q + STARVE_W'(1);
        end
`endif

        // The last sweep write ends INIT/SWEEP; sweep_idx wraps back to 0 on its own.
        if (sweep_gnt && (sweep_idx_q == '1)) begin
            state_d      = ST_IDLE;
            sweep_done_d = (state_q == ST_SWEEP);
        end
        if ((state_q == ST_IDLE) && sweep_start) begin
            state_d     = ST_SWEEP;
            sweep_idx_d = '0;
        end

        init_done_d    = init_done_q || (state_q == ST_IDLE);
        cpl_rd_valid_d = loc_rd_en_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            sweep_idx_q    <= '0;
            loc_index_q    <= '0;
            loc_rd_en_q    <= 1'b0;
            loc_wr_ways_q  <= '0;
            loc_wr_cline_q <= '0;
            cpl_rd_valid_q <= 1'b0;
            sweep_done_q   <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_idx_q    <= sweep_idx_d;
            loc_index_q    <= loc_index_d;
            loc_rd_en_q    <= loc_rd_en_d;
            loc_wr_ways_q  <= loc_wr_ways_d;
            loc_wr_cline_q <= loc_wr_cline_d;
            cpl_rd_valid_q <= cpl_rd_valid_d;
            sweep_done_q   <= sweep_done_d;
            init_done_q    <= init_done_d;
        end
    end

`ifdef HNF_LOC_SWEEP_STARVE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    assign sweep_busy    = (state_q != ST_IDLE);
    assign sweep_done    = sweep_done_q;
    assign init_done     = init_done_q;
    assign cpl_rd_valid  = cpl_rd_valid_q;
    assign cpl_rd_clines = loc_rd_clines_q;

endmodule

// File: tb/tb_hnf_loc_sram_seq.sv
// Directed bench for hnf_loc_sram_seq (IDX_W=4): INIT sweep, cpl read/write, invalidate sweep, starvation, reset abort.
module tb_hnf_loc_sram_seq;

    localparam int IDX_W   = 4;
    localparam int WAY_NUM = 16;
    localparam int CLINE_W = 8;
    localparam int RD_W    = CLINE_W * WAY_NUM;

    logic                clk;
    logic                rst_n;
    logic                cpl_req_valid;
    logic                cpl_req_ready;
    logic [IDX_W-1:0]    cpl_req_index;
    logic                cpl_req_rd_en;
    logic [WAY_NUM-1:0]  cpl_req_wr_ways;
    logic [CLINE_W-1:0]  cpl_req_wr_cline;
    logic                cpl_rd_valid;
    logic [RD_W-1:0]     cpl_rd_clines;
    logic                sweep_start;
    logic                sweep_busy;
    logic                sweep_done;
    logic                init_done;
    logic [IDX_W-1:0]    loc_index_q;
    logic                loc_rd_en_q;
    logic [WAY_NUM-1:0]  loc_wr_ways_q;
    logic [CLINE_W-1:0]  loc_wr_cline_q;
    logic [RD_W-1:0]     loc_rd_clines_q;

    int n_checks;
    int n_fail;

    hnf_loc_sram_seq #(
        .IDX_W      (IDX_W),
        .WAY_NUM    (WAY_NUM),
        .CLINE_W    (CLINE_W),
        .STARVE_MAX (15)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpl_req_valid    (cpl_req_valid),
        .cpl_req_ready    (cpl_req_ready),
        .cpl_req_index    (cpl_req_index),
        .cpl_req_rd_en    (cpl_req_rd_en),
        .cpl_req_wr_ways  (cpl_req_wr_ways),
        .cpl_req_wr_cline (cpl_req_wr_cline),
        .cpl_rd_valid     (cpl_rd_valid),
        .cpl_rd_clines    (cpl_rd_clines),
        .sweep_start      (sweep_start),
        .sweep_busy       (sweep_busy),
        .sweep_done       (sweep_done),
        .init_done        (init_done),
        .loc_index_q      (loc_index_q),
        .loc_rd_en_q      (loc_rd_en_q),
        .loc_wr_ways_q    (loc_wr_ways_q),
        .loc_wr_cline_q   (loc_wr_cline_q),
        .loc_rd_clines_q  (loc_rd_clines_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [RD_W-1:0] observed,
                               input logic [RD_W-1:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [IDX_W-1:0] idx, input logic rd,
                                 input logic [WAY_NUM-1:0] ways, input logic [CLINE_W-1:0] cline,
                                 input logic start);
        cpl_req_valid    = valid;
        cpl_req_index    = idx;
        cpl_req_rd_en    = rd;
        cpl_req_wr_ways  = ways;
        cpl_req_wr_cline = cline;
        sweep_start      = start;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState();
        checkOutput("rst_index", RD_W'(loc_index_q), '0);
        checkOutput("rst_rd_en", RD_W'(loc_rd_en_q), '0);
        checkOutput("rst_ways", RD_W'(loc_wr_ways_q), '0);
        checkOutput("rst_cline", RD_W'(loc_wr_cline_q), '0);
        checkOutput("rst_ready", RD_W'(cpl_req_ready), '0);
        checkOutput("rst_rd_valid", RD_W'(cpl_rd_valid), '0);
        checkOutput("rst_busy", RD_W'(sweep_busy), RD_W'(1));
        checkOutput("rst_done", RD_W'(sweep_done), '0);
        checkOutput("rst_init_done", RD_W'(init_done), '0);
    endtask

    initial begin
        int next_idx;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        loc_rd_clines_q = '0;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        #3;
        checkResetState();

        // INIT with a pending cpl read that must never be accepted.
        applyStimulus(1'b1, 4'd3, 1'b1, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checkOutput("init_ready", RD_W'(cpl_req_ready), '0);
            checkOutput("init_busy", RD_W'(sweep_busy), RD_W'(1));
            tick();
            checkOutput("init_index", RD_W'(loc_index_q), RD_W'(i));
            checkOutput("init_ways", RD_W'(loc_wr_ways_q), RD_W'(16'hFFFF));
            checkOutput("init_cline", RD_W'(loc_wr_cline_q), '0);
            checkOutput("init_rd_en", RD_W'(loc_rd_en_q), '0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("init_end_busy", RD_W'(sweep_busy), '0);
        checkOutput("init_done_early", RD_W'(init_done), '0);
        checkOutput("init_no_sweep_done", RD_W'(sweep_done), '0);
        tick();
        checkOutput("init_done_set", RD_W'(init_done), RD_W'(1));
        checkOutput("idle_ways_zero", RD_W'(loc_wr_ways_q), '0);
        checkOutput("idle_index_hold", RD_W'(loc_index_q), RD_W'(15));

        // IDLE read of index 5 followed by a write to index 9.
        applyStimulus(1'b1, 4'd5, 1'b1, '0, '0, 1'b0);
        checkOutput("idle_ready", RD_W'(cpl_req_ready), RD_W'(1));
        tick();
        checkOutput("rd_index", RD_W'(loc_index_q), RD_W'(5));
        checkOutput("rd_en", RD_W'(loc_rd_en_q), RD_W'(1));
        checkOutput("rd_ways", RD_W'(loc_wr_ways_q), '0);
        checkOutput("rd_valid_early", RD_W'(cpl_rd_valid), '0);
        applyStimulus(1'b1, 4'd9, 1'b0, 16'h00F0, 8'hA5, 1'b0);
        loc_rd_clines_q = {4{32'hDEADBEEF}};
        tick();
        checkOutput("rd_valid", RD_W'(cpl_rd_valid), RD_W'(1));
        checkOutput("rd_clines", cpl_rd_clines, {4{32'hDEADBEEF}});
        checkOutput("wr_index", RD_W'(loc_index_q), RD_W'(9));
        checkOutput("wr_ways", RD_W'(loc_wr_ways_q), RD_W'(16'h00F0));
        checkOutput("wr_cline", RD_W'(loc_wr_cline_q), RD_W'(8'hA5));
        checkOutput("wr_rd_en", RD_W'(loc_rd_en_q), '0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        tick();
        checkOutput("wr_no_valid", RD_W'(cpl_rd_valid), '0);
        checkOutput("nogrant_ways", RD_W'(loc_wr_ways_q), '0);
        checkOutput("nogrant_index", RD_W'(loc_index_q), RD_W'(9));
        checkOutput("nogrant_cline", RD_W'(loc_wr_cline_q), RD_W'(8'hA5));

        // Invalidate sweep with no cpl traffic; a second start mid-sweep is ignored.
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("pre_sweep_busy", RD_W'(sweep_busy), '0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("sweep_busy", RD_W'(sweep_busy), RD_W'(1));
            checkOutput("sweep_done_early", RD_W'(sweep_done), '0);
            applyStimulus(1'b0, '0, 1'b0, '0, '0, (i == 7));
            tick();
            checkOutput("sweep_index", RD_W'(loc_index_q), RD_W'(i));
            checkOutput("sweep_ways", RD_W'(loc_wr_ways_q), RD_W'(16'hFFFF));
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("sweep_done_pulse", RD_W'(sweep_done), RD_W'(1));
        checkOutput("sweep_end_busy", RD_W'(sweep_busy), '0);
        tick();
        checkOutput("sweep_done_clear", RD_W'(sweep_done), '0);
        checkOutput("sweep_idle_ways", RD_W'(loc_wr_ways_q), '0);
        tick();
        checkOutput("restart_ignored", RD_W'(sweep_busy), '0);
        checkOutput("single_done", RD_W'(sweep_done), '0);

        // sweep_start together with a cpl read, then cpl_req_valid held high.
        applyStimulus(1'b1, 4'd2, 1'b1, '0, '0, 1'b1);
        checkOutput("combo_ready", RD_W'(cpl_req_ready), RD_W'(1));
        tick();
        applyStimulus(1'b1, 4'd2, 1'b1, '0, '0, 1'b0);
        checkOutput("combo_index", RD_W'(loc_index_q), RD_W'(2));
        checkOutput("combo_rd_en", RD_W'(loc_rd_en_q), RD_W'(1));
        checkOutput("combo_busy", RD_W'(sweep_busy), RD_W'(1));
        for (int j = 0; j < 15; j++) begin
            checkOutput("starve_ready", RD_W'(cpl_req_ready), RD_W'(1));
            tick();
            checkOutput("starve_cpl_rd", RD_W'(loc_rd_en_q), RD_W'(1));
            checkOutput("starve_cpl_idx", RD_W'(loc_index_q), RD_W'(2));
        end
        checkOutput("starve_rd_valid", RD_W'(cpl_rd_valid), RD_W'(1));
`ifdef HNF_LOC_SWEEP_STARVE_EN
        checkOutput("forced_ready", RD_W'(cpl_req_ready), '0);
        tick();
        checkOutput("forced_index", RD_W'(loc_index_q), '0);
        checkOutput("forced_ways", RD_W'(loc_wr_ways_q), RD_W'(16'hFFFF));
        checkOutput("forced_rd_en", RD_W'(loc_rd_en_q), '0);
        checkOutput("after_forced_ready", RD_W'(cpl_req_ready), RD_W'(1));
        next_idx = 1;
`else
        checkOutput("strict_ready", RD_W'(cpl_req_ready), RD_W'(1));
        tick();
        checkOutput("strict_rd_en", RD_W'(loc_rd_en_q), RD_W'(1));
        checkOutput("strict_index", RD_W'(loc_index_q), RD_W'(2));
        next_idx = 0;
`endif

        // Let the sweep run until index 6 is written, then reset at sweep_idx 7.
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        for (int k = next_idx; k <= 6; k++) begin
            tick();
            checkOutput("resume_index", RD_W'(loc_index_q), RD_W'(k));
            checkOutput("resume_ways", RD_W'(loc_wr_ways_q), RD_W'(16'hFFFF));
        end
        rst_n = 1'b0;
        #1;
        checkResetState();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("reinit_index0", RD_W'(loc_index_q), '0);
        checkOutput("reinit_ways", RD_W'(loc_wr_ways_q), RD_W'(16'hFFFF));
        tick();
        checkOutput("reinit_index1", RD_W'(loc_index_q), RD_W'(1));
        checkOutput("reinit_init_done", RD_W'(init_done), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hnf_loc_sram_seq.md
# hnf_loc_sram_seq

Sequencer and arbiter for the HNF tag (loc) SRAM port. Out of reset it runs an initialization sweep that zeroes every index. Afterwards it shares the single SRAM port between the cpl pipeline and an on-demand invalidate sweep engine. All SRAM-side outputs are registered, and read data is returned to cpl with a matching valid.

## Interface
Parameters:
- IDX_W, 10, tag SRAM index width (depth = 2^IDX_W)
- WAY_NUM, 16, ways per set
- CLINE_W, 32, tag cline width per way
- STARVE_MAX, 15, consecutive cpl grants during SWEEP before one forced sweep slot

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- cpl_req_valid  in  1  cpl access request
- cpl_req_ready  out  1  request accepted this cycle
- cpl_req_index  in  IDX_W  request index
- cpl_req_rd_en  in  1  read request
- cpl_req_wr_ways  in  WAY_NUM  write way mask
- cpl_req_wr_cline  in  CLINE_W  write data
- cpl_rd_valid  out  1  read data valid
- cpl_rd_clines  out  CLINE_W*WAY_NUM  read data (pass-through of loc_rd_clines_q)
- sweep_start  in  1  pulse requesting an invalidate sweep
- sweep_busy  out  1  sweep in progress (INIT or SWEEP)
- sweep_done  out  1  one-cycle pulse at SWEEP completion
- init_done  out  1  level, high once INIT has completed
- loc_index_q  out  IDX_W  SRAM index (registered)
- loc_rd_en_q  out  1  SRAM read enable (registered)
- loc_wr_ways_q  out  WAY_NUM  SRAM write way mask (registered)
- loc_wr_cline_q  out  CLINE_W  SRAM write data (registered)
- loc_rd_clines_q  in  CLINE_W*WAY_NUM  SRAM read data, valid 1 cycle after loc_rd_en_q

## Operation
- FSM states: INIT, IDLE, SWEEP.
  - INIT is entered on reset and exits to IDLE after the last index is written.
  - IDLE goes to SWEEP on sweep_start.
  - SWEEP goes to IDLE after the last index is written.
- Sweep counter sweep_idx (IDX_W bits):
  - Cleared to 0 on entering INIT or SWEEP.
  - Increments on each sweep grant.
  - The last index is all-ones; the counter wraps to 0 on exit.
- A sweep grant drives the SRAM registers with: index=sweep_idx, rd_en=0, wr_ways=all ones, wr_cline=0.
- INIT:
  - cpl_req_ready=0.
  - A sweep grant occurs every cycle.
- IDLE:
  - cpl_req_ready=1.
  - A granted cpl request is copied into the SRAM registers unchanged.
  - With no grant, the SRAM registers hold rd_en=0 and wr_ways=0; index and cline hold their previous value.
- SWEEP:
  - cpl has priority.
  - The sweep is granted whenever cpl_req_valid=0 or a starvation slot is forced (see Configuration).
  - cpl_req_ready=0 in a forced-slot cycle.
- sweep_start in INIT or SWEEP is ignored (not queued).
- sweep_start together with cpl_req_valid in IDLE: the cpl request is granted that cycle and the FSM moves to SWEEP.
- sweep_busy=1 in INIT and SWEEP.
- sweep_done pulses in the cycle after the final SWEEP write is registered. There is no pulse for INIT.
- init_done is set when INIT exits and is cleared only by reset.
- Read tracking: a one-bit pipeline of granted cpl reads.
  - cpl_rd_valid is aligned with loc_rd_clines_q.
  - Accepted writes and sweep writes never assert cpl_rd_valid.
- Reset mid-sweep aborts the sweep. After rst_n rises, the block restarts INIT from index 0.

## Timing
- Reset values: loc_index_q=0, loc_rd_en_q=0, loc_wr_ways_q=0, loc_wr_cline_q=0, cpl_req_ready=0, cpl_rd_valid=0, sweep_busy=1 (INIT), sweep_done=0, init_done=0.
- cpl_req_ready is combinational from the FSM state and starvation counter. It does not depend on cpl_req_valid.
- A cpl request accepted at edge T appears on the loc_* outputs after edge T. Its read data and cpl_rd_valid appear after edge T+1 (2-cycle read latency from acceptance).
- INIT duration: after rst_n deasserts, edges 1..2^IDX_W each register one write; init_done=1 after edge 2^IDX_W+1.
- Throughput: one SRAM access per cycle; there are no bubbles between back-to-back cpl grants.

## Configuration
- HNF_LOC_SWEEP_STARVE_EN defined:
  - A 4+-bit counter counts consecutive cpl grants in SWEEP.
  - When the count equals STARVE_MAX, the next cycle is a forced sweep slot and the counter clears.
  - The counter also clears on any sweep grant and on leaving SWEEP.
- HNF_LOC_SWEEP_STARVE_EN undefined: strict cpl priority with no counter. The sweep can be starved indefinitely.

## Test plan
- Reset release, no traffic, IDX_W=4 -> 16 consecutive writes to indices 0..15 with wr_ways=0xFFFF and cline=0; init_done high after edge 17; cpl_req_ready=0 throughout INIT.
- IDLE, cpl read of index 5 accepted at edge T -> loc_index_q=5 and loc_rd_en_q=1 after T; cpl_rd_valid=1 with cpl_rd_clines equal to the SRAM data after T+1; no valid for a following write.
- sweep_start in IDLE, no cpl traffic, IDX_W=4 -> 16 sweep writes, sweep_busy=1 during them, sweep_done pulses exactly once, return to IDLE.
- SWEEP with cpl_req_valid held high, STARVE_MAX=15, macro defined -> pattern of 15 cpl grants then 1 sweep slot with cpl_req_ready=0; macro undefined -> sweep_idx frozen.
- sweep_start pulsed again mid-SWEEP -> ignored; exactly one sweep_done.
- rst_n asserted at sweep_idx=7 -> all outputs return to reset values immediately; after release, INIT restarts at index 0.
